// File: rtl/clock_ctrl_pkg.sv
// Shared types, limits and helpers for the clock time-set controller.
package clock_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned IDLE_W  = 29;
  localparam int unsigned BCD_W   = 8;
  localparam int unsigned SEL_W   = 3;

  localparam logic [STATE_W-1:0] ST_RUN   = 3'd0;
  localparam logic [STATE_W-1:0] ST_SET_H = 3'd1;
  localparam logic [STATE_W-1:0] ST_SET_M = 3'd2;
  localparam logic [STATE_W-1:0] ST_SET_S = 3'd3;
  localparam logic [STATE_W-1:0] ST_LOAD  = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    RUN   = ST_RUN,
    SET_H = ST_SET_H,
    SET_M = ST_SET_M,
    SET_S = ST_SET_S,
    LOAD  = ST_LOAD
  } state_t;

  localparam logic [BCD_W-1:0] HOUR_MAX   = 8'h23;
  localparam logic [BCD_W-1:0] MINSEC_MAX = 8'h59;

  typedef struct packed {
    logic [BCD_W-1:0] hour;
    logic [BCD_W-1:0] min;
    logic [BCD_W-1:0] sec;
  } bcd_time_t;

  // Any malformed or out-of-range captured field restarts editing from 00.
  function automatic logic [BCD_W-1:0] bcd_sanitize(input logic [BCD_W-1:0] v,
                                                    input logic [BCD_W-1:0] max);
    if ((v[3:0] > 4'd9) || (v > max)) return 8'h00;
    return v;
  endfunction

  // One-hot {hour,min,sec} field select for a given state.
  function automatic logic [SEL_W-1:0] sel_of(input state_t s);
    case (s)
      SET_H:   return 3'b100;
      SET_M:   return 3'b010;
      SET_S:   return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bcd_wrap_inc.sv
// Combinational BCD +1 with wrap to 00 once the supplied maximum is reached.
module bcd_wrap_inc
  import clock_ctrl_pkg::*;
(
  input  logic [BCD_W-1:0] val,
  input  logic [BCD_W-1:0] max,
  output logic [BCD_W-1:0] inc_c
);

  always_comb begin
    inc_c = 8'h00;
    if (val < max) begin
      if (val[3:0] >= 4'd9) inc_c = {val[7:4] + 4'd1, 4'd0};
      else                  inc_c = val + 8'd1;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven hour/min/sec set sequencer in front of the BCD clock counter.
// Optional digit blinking is built when CLOCK_SET_BLINK_EN is defined.
module clock_set_ctrl
  import clock_ctrl_pkg::*;
#(
`ifdef CLOCK_SET_BLINK_EN
  parameter int unsigned BLINK_DIV    = 12_500_000,
`endif
  parameter int unsigned IDLE_TIMEOUT = 500_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [BCD_W-1:0] cur_hour,
  input  logic [BCD_W-1:0] cur_min,
  input  logic [BCD_W-1:0] cur_sec,
  output logic [BCD_W-1:0] hour_in,
  output logic [BCD_W-1:0] min_in,
  output logic [BCD_W-1:0] sec_in,
  output logic             hour_ld,
  output logic             min_ld,
  output logic             sec_ld,
  output logic             cnt_en,
  output logic [SEL_W-1:0] edit_sel,
  output logic [5:0]       digit_blank
);

  state_t            state_q, state_d;
  bcd_time_t         edit_q, edit_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [BCD_W-1:0]  inc_src, inc_max, inc_res;
  logic              timeout_hit;
  logic              load_q, cnt_en_q;
  logic [SEL_W-1:0]  sel_q;

  // Single incrementer shared by whichever field is being edited.
  always_comb begin
    inc_src = edit_q.sec;
    inc_max = MINSEC_MAX;
    case (state_q)
      SET_H:   begin inc_src = edit_q.hour; inc_max = HOUR_MAX; end
      SET_M:   inc_src = edit_q.min;
      default: ;
    endcase
  end

  bcd_wrap_inc u_inc (
    .val   (inc_src),
    .max   (inc_max),
    .inc_c (inc_res)
  );

  assign timeout_hit = (idle_q == IDLE_W'(IDLE_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Next state, edit fields and idle counter; mode outranks inc.
  always_comb begin
    state_d = state_q;
    edit_d  = edit_q;
    idle_d  = '0;
    case (state_q)
      RUN: begin
        if (btn_mode) begin
          state_d     = SET_H;
          edit_d.hour = bcd_sanitize(cur_hour, HOUR_MAX);
          edit_d.min  = bcd_sanitize(cur_min, MINSEC_MAX);
          edit_d.sec  = bcd_sanitize(cur_sec, MINSEC_MAX);
        end
      end
      SET_H, SET_M, SET_S: begin
        if (btn_mode) begin
          state_d = (state_q == SET_H) ? SET_M :
                    (state_q == SET_M) ? SET_S : LOAD;
        end else if (btn_inc) begin
          case (state_q)
            SET_H:   edit_d.hour = inc_res;
            SET_M:   edit_d.min  = inc_res;
            default: edit_d.sec  = inc_res;
          endcase
        end else if (timeout_hit) begin
          state_d = RUN;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
        end
      end
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edit_q   <= '0;
      idle_q   <= '0;
      load_q   <= 1'b0;
      cnt_en_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      edit_q   <= edit_d;
      idle_q   <= idle_d;
      load_q   <= (state_d == LOAD);
      cnt_en_q <= (state_d == RUN);
      sel_q    <= sel_of(state_d);
    end
  end

  assign hour_in  = edit_q.hour;
  assign min_in   = edit_q.min;
  assign sec_in   = edit_q.sec;
  assign hour_ld  = load_q;
  assign min_ld   = load_q;
  assign sec_ld   = load_q;
  assign cnt_en   = cnt_en_q;
  assign edit_sel = sel_q;

`ifdef CLOCK_SET_BLINK_EN
  localparam int unsigned DIV_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             blink_q, blink_d;
  logic [SEL_W-1:0] sel_d;
  logic [5:0]       blank_q;

  // Blink phase restarts on every state change so a new field starts visible.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    blink_d = blink_q;
    sel_d   = sel_of(state_d);
    if (state_d != state_q) begin
      div_d   = '0;
      blink_d = 1'b0;
    end else if (div_q == DIV_W'(BLINK_DIV - 1)) begin
      div_d   = '0;
      blink_d = ~blink_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= '0;
      blink_q <= 1'b0;
      blank_q <= '0;
    end else begin
      div_q   <= div_d;
      blink_q <= blink_d;
      blank_q <= blink_d ? {{2{sel_d[2]}}, {2{sel_d[1]}}, {2{sel_d[0]}}} : 6'b0;
    end
  end

  assign digit_blank = blank_q;
`else
  assign digit_blank = 6'b0;
`endif

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomised and directed bench for clock_set_ctrl against a decimal time-set model.
module tb_clock_set_ctrl;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] cur_hour = 8'h00;
  logic [7:0] cur_min = 8'h00;
  logic [7:0] cur_sec = 8'h00;
  logic [7:0] hour_in, min_in, sec_in;
  logic       hour_ld, min_ld, sec_ld, cnt_en;
  logic [2:0] edit_sel;
  logic [5:0] digit_blank;

  int checks = 0;
  int failures = 0;

  // Model: 0=running, 1..3=editing hour/min/sec, 4=load; fields held as decimal ints.
  int m_st;
  int m_f[3];
  int m_idle;
  bit m_en;

  clock_set_ctrl #(.IDLE_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
    .hour_in(hour_in), .min_in(min_in), .sec_in(sec_in),
    .hour_ld(hour_ld), .min_ld(min_ld), .sec_ld(sec_ld),
    .cnt_en(cnt_en), .edit_sel(edit_sel), .digit_blank(digit_blank)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) + (v % 10));
  endfunction

  function automatic int field_max(input int i);
    return (i == 0) ? 23 : 59;
  endfunction

  function automatic int capture(input logic [7:0] v, input int max);
    int lo, hi;
    lo = int'(v[3:0]);
    hi = int'(v[7:4]);
    if (lo <= 9 && (hi * 10 + lo) <= max) return hi * 10 + lo;
    return 0;
  endfunction

  task automatic model_reset();
    m_st = 0; m_f[0] = 0; m_f[1] = 0; m_f[2] = 0; m_idle = 0; m_en = 1'b0;
  endtask

  task automatic model_step(input bit mode, input bit inc);
    if (m_st == 4) begin
      m_st = 0;
    end else if (m_st == 0) begin
      if (mode) begin
        m_f[0] = capture(cur_hour, 23);
        m_f[1] = capture(cur_min, 59);
        m_f[2] = capture(cur_sec, 59);
        m_st = 1;
        m_idle = 0;
      end
    end else begin
      if (mode) begin
        m_st++;
        m_idle = 0;
      end else if (inc) begin
        m_f[m_st-1] = (m_f[m_st-1] + 1) % (field_max(m_st-1) + 1);
        m_idle = 0;
      end else if (m_idle == TO - 1) begin
        m_st = 0;
      end else begin
        m_idle++;
      end
    end
    m_en = (m_st == 0);
  endtask

  task automatic check_all();
    logic [2:0] sel;
    sel = (m_st >= 1 && m_st <= 3) ? 3'(4 >> (m_st - 1)) : 3'b000;
    chk("hour_in", 32'(hour_in), 32'(to_bcd(m_f[0])));
    chk("min_in", 32'(min_in), 32'(to_bcd(m_f[1])));
    chk("sec_in", 32'(sec_in), 32'(to_bcd(m_f[2])));
    chk("hour_ld", 32'(hour_ld), 32'(m_st == 4));
    chk("min_ld", 32'(min_ld), 32'(m_st == 4));
    chk("sec_ld", 32'(sec_ld), 32'(m_st == 4));
    chk("cnt_en", 32'(cnt_en), 32'(m_en));
    chk("edit_sel", 32'(edit_sel), 32'(sel));
    chk("digit_blank", 32'(digit_blank), 32'd0);
  endtask

  task automatic cycle(input bit mode, input bit inc);
    @(negedge clk);
    btn_mode = mode;
    btn_inc  = inc;
    @(posedge clk);
    model_step(mode, inc);
    #1;
    check_all();
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    cur_hour = h; cur_min = m; cur_sec = s;
  endtask

  initial begin
    int pm;
    model_reset();

    // Reset held for 5 clocks, then released.
    repeat (5) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    chk("cnt_en_after_reset", 32'(cnt_en), 32'd1);

    // Full edit from 23:59:58 with one hour increment.
    set_cur(8'h23, 8'h59, 8'h58);
    cycle(1'b1, 1'b0);
    chk("edit_cnt_en_off", 32'(cnt_en), 32'd0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    chk("load_hour", 32'(hour_in), 32'h00);
    chk("load_min", 32'(min_in), 32'h59);
    chk("load_sec", 32'(sec_in), 32'h58);
    chk("load_ld", 32'({hour_ld, min_ld, sec_ld}), 32'h7);
    cycle(1'b0, 1'b0);
    chk("post_load_cnt_en", 32'(cnt_en), 32'd1);
    chk("post_load_ld", 32'(hour_ld), 32'd0);

    // Minute wrap 58 -> 00 and 09 -> 10.
    set_cur(8'h10, 8'h58, 8'h00);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("wrap_min_00", 32'(min_in), 32'h00);
    repeat (9) cycle(1'b0, 1'b1);
    chk("min_09", 32'(min_in), 32'h09);
    cycle(1'b0, 1'b1);
    chk("min_10", 32'(min_in), 32'h10);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    // Mode and inc together in SET_H: advance, hour untouched.
    set_cur(8'h07, 8'h00, 8'h00);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    chk("simul_sel", 32'(edit_sel), 32'b010);
    chk("simul_hour", 32'(hour_in), 32'h07);

    // Timeout from SET_S after 100 idle cycles, no load.
    cycle(1'b1, 1'b0);
    repeat (TO - 1) cycle(1'b0, 1'b0);
    chk("pre_timeout_sel", 32'(edit_sel), 32'b001);
    cycle(1'b0, 1'b0);
    chk("timeout_cnt_en", 32'(cnt_en), 32'd1);
    chk("timeout_ld", 32'(sec_ld), 32'd0);

    // Reset mid-edit in SET_M, then sanitised capture of a bad hour.
    set_cur(8'h12, 8'h34, 8'h56);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    @(negedge clk) rst_n = 1'b0;
    #1 model_reset();
    check_all();
    chk("rst_mid_sel", 32'(edit_sel), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    cycle(1'b0, 1'b0);
    set_cur(8'h2A, 8'h3B, 8'h60);
    cycle(1'b1, 1'b0);
    chk("sanitise_hour", 32'(hour_in), 32'h00);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);

    // Randomised blocks alternating busy pressing with long idle stretches.
    for (int blk = 0; blk < 20; blk++) begin
      pm = (blk % 3 == 2) ? 1 : 25;
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(0, 3) == 0)
          set_cur(8'($urandom), 8'($urandom), 8'($urandom));
        else
          set_cur(to_bcd(int'($urandom_range(0, 23))), to_bcd(int'($urandom_range(0, 59))),
                  to_bcd(int'($urandom_range(0, 59))));
        cycle(($urandom_range(0, 99) < pm), ($urandom_range(0, 99) < 3 * pm));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
